// File: rtl/cpu_program_loader.sv
// cpu_program_loader
//   Streams framed 32-bit host words into the cpu instruction or data memory
//   through the cpu external write ports, then optionally runs the cpu until
//   a halt request arrives.
//
//   Frame = one header word followed by N payload words.
//     header[31]    target (0 = IMEM, 1 = DMEM)
//     header[30]    start  (enter RUN once the frame completes)
//     header[29:16] base word index
//     header[15:0]  N payload words
//
//   Ports
//     clk, arst_n            clock, asynchronous active-low reset
//     s_valid/s_ready/s_data host word stream (transfer on valid & ready)
//     halt                   one-cycle request to leave RUN
//     imem_addr/wen/wdata    to cpu addr_ext / wen_ext / wdata_ext
//     dmem_addr/wen/wdata    to cpu addr_ext_2 / wen_ext_2 / wdata_ext_2
//     cpu_enable             to cpu enable
//     words_loaded           payload words accepted since the last header
//     busy                   high whenever the loader is not IDLE
//
//   Optional build macro LOADER_READBACK_EN adds imem_ren/imem_rdata,
//   dmem_ren/dmem_rdata and a sticky verify_err: every write is read back
//   and compared, and a frame that failed verification never starts the cpu.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for a header word
//   LOAD   | accepting payload words, one write pulse per word
//   RUN    | cpu enabled until halt
//   WR     | (readback) write pulse in flight, stream stalled
//   RD     | (readback) read strobe in flight, stream stalled
//   FIN    | (readback) last word being compared, decide RUN or IDLE

module cpu_program_loader #(
  parameter int IMEM_ADDR_W = 9,
  parameter int DMEM_ADDR_W = 10,
  parameter int BYTE_SHIFT  = 2
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        halt,
  output logic [31:0] imem_addr,
  output logic        imem_wen,
  output logic [31:0] imem_wdata,
  output logic [31:0] dmem_addr,
  output logic        dmem_wen,
  output logic [31:0] dmem_wdata,
`ifdef LOADER_READBACK_EN
  output logic        imem_ren,
  input  logic [31:0] imem_rdata,
  output logic        dmem_ren,
  input  logic [31:0] dmem_rdata,
  output logic        verify_err,
`endif
  output logic        cpu_enable,
  output logic [15:0] words_loaded,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_WR   = 3'd3,
    S_RD   = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        tgt_q;
  logic        start_q;
  logic [13:0] idx_q;
  logic [15:0] remaining_q;
  logic        accept;
  logic [31:0] imem_addr_nx;
  logic [31:0] dmem_addr_nx;

  assign accept  = s_valid & s_ready;
  assign s_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign busy    = (state_q != S_IDLE);

  // Index wraps naturally by keeping only the low ADDR_W bits of the running index.
  assign imem_addr_nx = {{(32-IMEM_ADDR_W){1'b0}}, idx_q[IMEM_ADDR_W-1:0]} << BYTE_SHIFT;
  assign dmem_addr_nx = {{(32-DMEM_ADDR_W){1'b0}}, idx_q[DMEM_ADDR_W-1:0]} << BYTE_SHIFT;

`ifdef LOADER_READBACK_EN
  logic        cmp_pending;
  logic        mismatch;
  logic [31:0] rdata_sel;
  logic [31:0] wdata_sel;

  assign rdata_sel = tgt_q ? dmem_rdata : imem_rdata;
  assign wdata_sel = tgt_q ? dmem_wdata : imem_wdata;
  assign mismatch  = cmp_pending && (rdata_sel != wdata_sel);
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (s_data[15:0] != 16'd0) state_d = S_LOAD;
          else if (s_data[30])       state_d = S_RUN;
        end
      end
      S_LOAD: begin
        if (accept) begin
`ifdef LOADER_READBACK_EN
          state_d = S_WR;
`else
          if (remaining_q == 16'd1) state_d = start_q ? S_RUN : S_IDLE;
`endif
        end
      end
      S_RUN: begin
        if (halt) state_d = S_IDLE;
      end
`ifdef LOADER_READBACK_EN
      S_WR:  state_d = S_RD;
      S_RD:  state_d = (remaining_q == 16'd0) ? S_FIN : S_LOAD;
      S_FIN: state_d = (start_q && !verify_err && !mismatch) ? S_RUN : S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tgt_q        <= 1'b0;
      start_q      <= 1'b0;
      idx_q        <= '0;
      remaining_q  <= '0;
      words_loaded <= '0;
      imem_addr    <= '0;
      imem_wen     <= 1'b0;
      imem_wdata   <= '0;
      dmem_addr    <= '0;
      dmem_wen     <= 1'b0;
      dmem_wdata   <= '0;
      cpu_enable   <= 1'b0;
    end else begin
      imem_wen   <= 1'b0;
      dmem_wen   <= 1'b0;
      // Enable lags RUN entry by one cycle, so the last write pulse never overlaps it.
      cpu_enable <= (state_q == S_RUN) && !halt;

      if (accept && state_q == S_IDLE) begin
        tgt_q        <= s_data[31];
        start_q      <= s_data[30];
        idx_q        <= s_data[29:16];
        remaining_q  <= s_data[15:0];
        words_loaded <= '0;
      end

      if (accept && state_q == S_LOAD) begin
        remaining_q <= remaining_q - 16'd1;
        idx_q       <= idx_q + 14'd1;
        if (words_loaded != 16'hFFFF) words_loaded <= words_loaded + 16'd1;
        if (tgt_q) begin
          dmem_wen   <= 1'b1;
          dmem_addr  <= dmem_addr_nx;
          dmem_wdata <= s_data;
        end else begin
          imem_wen   <= 1'b1;
          imem_addr  <= imem_addr_nx;
          imem_wdata <= s_data;
        end
      end
    end
  end

`ifdef LOADER_READBACK_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      imem_ren    <= 1'b0;
      dmem_ren    <= 1'b0;
      cmp_pending <= 1'b0;
      verify_err  <= 1'b0;
    end else begin
      // Read strobe follows the write pulse at the still-held address.
      imem_ren    <= (state_q == S_WR) && !tgt_q;
      dmem_ren    <= (state_q == S_WR) && tgt_q;
      cmp_pending <= (state_q == S_RD);
      if (accept && state_q == S_IDLE) verify_err <= 1'b0;
      else if (mismatch)               verify_err <= 1'b1;
    end
  end
`endif

endmodule
